gdp_frame_scorer: RTL

//  Parametrised successor to the single-shot GDP controller. Scores one feature vector against
//  N_SENONES diagonal Gaussians: score[s] = k[s] - sum_d omega[s,d]*(x[d]-mean[s,d])^2.

---
 rtl/gdp_pkg.sv | 33 +++
 rtl/gdp_term_unit.sv | 35 +++
 rtl/gdp_frame_scorer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gdp_pkg.sv
// Shared types, widths and saturation helpers for the GDP frame scorer.
package gdp_pkg;

  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 32;

  typedef logic signed [W-1:0]     num;
  typedef logic signed [ACC_W-1:0] acc_t;
  // Two guard bits above the accumulator, enough for one add/sub of ACC_W operands.
  typedef logic signed [ACC_W+1:0] wide_t;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, SCORE} state_t;

  // Clamp a guarded value into the signed ACC_W range.
  function automatic acc_t sat_acc(input wide_t v);
    logic [2:0] top;
    top = v[ACC_W+1:ACC_W-1];
    if (top == 3'b000 || top == 3'b111) return v[ACC_W-1:0];
    else if (v[ACC_W+1])                return {1'b1, {(ACC_W-1){1'b0}}};
    else                                return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  // Clamp a guarded value into the signed W range.
  function automatic num sat_w(input wide_t v);
    logic [ACC_W-W+2:0] top;
    top = v[ACC_W+1:W-1];
    if (top == '0 || top == '1) return v[W-1:0];
    else if (v[ACC_W+1])        return {1'b1, {(W-1){1'b0}}};
    else                        return {1'b0, {(W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/gdp_term_unit.sv
// One weighted squared-distance term: ((x_d-mean)^2 >>> FRAC) * omega >>> FRAC,
// saturated to the accumulator width. Purely combinational.
module gdp_term_unit
  import gdp_pkg::*;
(
  input  num   x_d,
  input  num   mean,
  input  num   omega,
  output acc_t term
);

  localparam int SQ_W = 2*W + 2;
  localparam int PW   = 3*W + 2 - FRAC;

  logic signed [W:0]           diff;
  logic signed [SQ_W-1:0]      diff_ext;
  logic signed [SQ_W-1:0]      sq_full;
  logic signed [SQ_W-FRAC-1:0] sq;
  logic signed [PW-1:0]        sq_ext;
  logic signed [PW-1:0]        omega_ext;
  logic signed [PW-1:0]        prod;

  // Square the difference, rescale, weight by omega, rescale and saturate.
  always_comb begin
    diff      = {x_d[W-1], x_d} - {mean[W-1], mean};
    diff_ext  = {{(W+1){diff[W]}}, diff};
    sq_full   = diff_ext * diff_ext;
    sq        = (SQ_W-FRAC)'(sq_full >>> FRAC);
    sq_ext    = {{(PW-(SQ_W-FRAC)){sq[SQ_W-FRAC-1]}}, sq};
    omega_ext = {{(PW-W){omega[W-1]}}, omega};
    prod      = sq_ext * omega_ext;
    term      = sat_acc(wide_t'(prod >>> FRAC));
  end

endmodule

// File: rtl/gdp_frame_scorer.sv
// Scores one feature vector against N_SENONES diagonal Gaussians, fetching one
// stats tuple per dimension and streaming saturated scores out with their index.
// Optional feature: define GDP_VECTOR_BUFFER_EN for a one-deep shadow vector that
// chains the next frame without returning to IDLE.
module gdp_frame_scorer
  import gdp_pkg::*;
#(
  parameter int N_DIM     = 26,
  parameter int N_SENONES = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_vector_available,
  input  num                           x [N_DIM],
  output logic                         get_new_stats,
  input  logic                         new_stats_available,
  input  num                           mean,
  input  num                           omega,
  input  num                           k,
  output logic [$clog2(N_SENONES)-1:0] senone_index,
  output num                           senone_score,
  output logic                         score_ready,
  output logic                         gdp_idle,
  output logic                         vector_overrun
);

  localparam int DW = $clog2(N_DIM);
  localparam int SW = $clog2(N_SENONES);
  localparam logic [DW-1:0] D_LAST = DW'(N_DIM - 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_SENONES - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   d_q;
  logic [SW-1:0]   s_q;
  acc_t            acc_q;
  num              vec_q [N_DIM];
  num              mean_q, omega_q, k_q;
  acc_t            term;
  acc_t            acc_next;
  num              score_next;
  wide_t           acc_ext, term_ext, k_ext;

`ifdef GDP_VECTOR_BUFFER_EN
  num              shadow_q [N_DIM];
  logic            pending_q;
  logic            reload;
  assign reload = (state_q == SCORE) && (s_q == S_LAST) && pending_q;
`endif

  gdp_term_unit u_term (
    .x_d   (vec_q[d_q]),
    .mean  (mean_q),
    .omega (omega_q),
    .term  (term)
  );

  assign acc_ext    = {{2{acc_q[ACC_W-1]}}, acc_q};
  assign term_ext   = {{2{term[ACC_W-1]}}, term};
  assign k_ext      = {{(ACC_W+2-W){k_q[W-1]}}, k_q};
  assign acc_next   = sat_acc(acc_ext + term_ext);
  assign score_next = sat_w(k_ext - acc_ext);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_d       = state_q;
    get_new_stats = 1'b0;
    gdp_idle      = (state_q == IDLE);
    case (state_q)
      IDLE:  if (new_vector_available) state_d = FETCH;
      FETCH: begin
        get_new_stats = 1'b1;
        if (new_stats_available) state_d = MAC;
      end
      MAC:   state_d = (d_q == D_LAST) ? SCORE : FETCH;
      SCORE: begin
        if (s_q != S_LAST) state_d = FETCH;
`ifdef GDP_VECTOR_BUFFER_EN
        else               state_d = pending_q ? FETCH : IDLE;
`else
        else               state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, vector/stats capture, accumulator and registered score outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q            <= '0;
      s_q            <= '0;
      acc_q          <= '0;
      mean_q         <= '0;
      omega_q        <= '0;
      k_q            <= '0;
      senone_index   <= '0;
      senone_score   <= '0;
      score_ready    <= 1'b0;
      vector_overrun <= 1'b0;
      for (int unsigned i = 0; i < N_DIM; i++) vec_q[i] <= '0;
`ifdef GDP_VECTOR_BUFFER_EN
      for (int unsigned i = 0; i < N_DIM; i++) shadow_q[i] <= '0;
      pending_q      <= 1'b0;
`endif
    end else begin
      score_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (new_vector_available) begin
            vec_q <= x;
            s_q   <= '0;
            d_q   <= '0;
            acc_q <= '0;
          end
        end
        FETCH: begin
          if (new_stats_available) begin
            mean_q  <= mean;
            omega_q <= omega;
            if (d_q == '0) k_q <= k;
          end
        end
        MAC: begin
          acc_q <= acc_next;
          if (d_q != D_LAST) d_q <= d_q + 1'b1;
        end
        SCORE: begin
          senone_score <= score_next;
          senone_index <= s_q;
          score_ready  <= 1'b1;
          d_q          <= '0;
          acc_q        <= '0;
          if (s_q == S_LAST) begin
            s_q <= '0;
`ifdef GDP_VECTOR_BUFFER_EN
            if (pending_q) vec_q <= shadow_q;
`endif
          end else begin
            s_q <= s_q + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef GDP_VECTOR_BUFFER_EN
      // A busy-time arrival always lands in the shadow; only a still-full shadow
      // counts as an overrun, and it beats the clear from a same-cycle reload.
      if (new_vector_available && state_q != IDLE) begin
        shadow_q       <= x;
        pending_q      <= 1'b1;
        vector_overrun <= pending_q && !reload;
      end else begin
        vector_overrun <= 1'b0;
        if (reload) pending_q <= 1'b0;
      end
`else
      vector_overrun <= new_vector_available && (state_q != IDLE);
`endif
    end
  end

endmodule
